// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the CPU/debug memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DBG = 1'b1
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  localparam int DEFAULT_WORDS = 512;

endpackage

// File: rtl/arbiter_hold_counter.sv
// Saturating count of consecutive CPU grants taken while debug is waiting.
// at_max flags the increment that brings the count up to MAX_HOLD, so the
// arbiter can schedule the forced debug slot for the very next cycle.
module arbiter_hold_counter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_BITS = $clog2(MAX_HOLD + 1)
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  input  logic clear,
  output logic at_max
);

  localparam logic [CNT_BITS-1:0] MAX_VAL = CNT_BITS'(MAX_HOLD);

  logic [CNT_BITS-1:0] count;

  assign at_max = inc && (count == MAX_VAL - 1'b1);

  // count CPU grants under debug pressure; clear wins over increment
  always_ff @(posedge clk) begin
    if (!clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the single-port program memory between the CPU datapath and the
// debug/loader port. CPU has priority; a hold counter forces one debug slot
// after MAX_HOLD back-to-back CPU grants, and dbg_lock excludes the CPU.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int WORDS     = DEFAULT_WORDS,
  parameter int ADDR_BITS = $clog2(WORDS),
  parameter int MAX_HOLD  = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [BITS-1:0]      cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [BITS-1:0]      cpu_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  input  logic [BITS-1:0]      dbg_wdata,
  input  logic                 dbg_lock,
  output logic                 dbg_gnt,
  output logic                 dbg_rvalid,
  output logic [BITS-1:0]      dbg_rdata,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [BITS-1:0]      mem_data_in,
  output logic                 mem_en,
  input  logic [BITS-1:0]      mem_data_out
);

  arb_state_t state;
  logic       rd_pending;
  logic       rd_owner;
  logic       cpu_win;
  logic       dbg_win;
  logic       hold_inc;
  logic       hold_clear;
  logic       hold_at_max;
  logic       enter_dbg;

  // grant decision: lock or the forced slot favour debug, otherwise CPU first
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (clr) begin
      if (dbg_lock || (state == S_DBG)) begin
        dbg_win = dbg_req;
        cpu_win = cpu_req && !dbg_req && !dbg_lock;
      end else begin
        cpu_win = cpu_req;
        dbg_win = dbg_req && !cpu_req;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign dbg_gnt = dbg_win;

  // steer the granted port onto the memory; idle bus is all zeros
  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    mem_en      = 1'b0;
    if (cpu_win) begin
      mem_address = cpu_addr;
      mem_data_in = cpu_wdata;
      mem_en      = cpu_we;
    end else if (dbg_win) begin
      mem_address = dbg_addr;
      mem_data_in = dbg_wdata;
      mem_en      = dbg_we;
    end
  end

  assign hold_inc   = cpu_win && dbg_req;
  assign enter_dbg  = (state == S_CPU) && hold_at_max;
  assign hold_clear = dbg_win || !dbg_req || enter_dbg;

  arbiter_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk    (clk),
    .clr    (clr),
    .inc    (hold_inc),
    .clear  (hold_clear),
    .at_max (hold_at_max)
  );

  // priority state and read-return tracking
  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= S_CPU;
      rd_pending <= 1'b0;
      rd_owner   <= OWNER_CPU;
    end else begin
      if (state == S_DBG) begin
        state <= S_CPU;
      end else if (hold_at_max) begin
        state <= S_DBG;
      end
      rd_pending <= (cpu_win && !cpu_we) || (dbg_win && !dbg_we);
      rd_owner   <= dbg_win ? OWNER_DBG : OWNER_CPU;
    end
  end

  // memory output is registered, so read data lines up with rd_pending
  assign cpu_rvalid = clr && rd_pending && (rd_owner == OWNER_CPU);
  assign dbg_rvalid = clr && rd_pending && (rd_owner == OWNER_DBG);
  assign cpu_rdata  = mem_data_out;
  assign dbg_rdata  = mem_data_out;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  localparam int BITS      = 32;
  localparam int WORDS     = 512;
  localparam int ADDR_BITS = 9;
  localparam int MAX_HOLD  = 4;

  logic                 clk = 1'b0;
  logic                 clr = 1'b0;
  logic                 cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_BITS-1:0] cpu_addr = '0;
  logic [BITS-1:0]      cpu_wdata = '0;
  logic                 cpu_gnt, cpu_rvalid;
  logic [BITS-1:0]      cpu_rdata;
  logic                 dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [ADDR_BITS-1:0] dbg_addr = '0;
  logic [BITS-1:0]      dbg_wdata = '0;
  logic                 dbg_gnt, dbg_rvalid;
  logic [BITS-1:0]      dbg_rdata;
  logic [ADDR_BITS-1:0] mem_address;
  logic [BITS-1:0]      mem_data_in;
  logic                 mem_en;
  logic [BITS-1:0]      mem_data_out;

  logic [BITS-1:0] mem     [WORDS];
  logic [BITS-1:0] ref_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  memory_arbiter #(
    .BITS(BITS), .WORDS(WORDS), .ADDR_BITS(ADDR_BITS), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .clr(clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_en(mem_en),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // single-port memory with registered read output
  always @(posedge clk) begin
    if (mem_en) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  task automatic go_idle(input int n);
    @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h3; cpu_wdata = 32'h1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h5; dbg_wdata = '1; dbg_lock = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en} !== 5'b0 ||
          mem_address !== '0 || mem_data_in !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: gnt=%b/%b rvalid=%b/%b en=%b addr=%h din=%h, required all zero",
                 cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, mem_address, mem_data_in);
      end
    end
    @(negedge clk); clr = 1'b1; #1;
    n_checks++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_grant: cpu_gnt=%b dbg_gnt=%b, required 1/0", cpu_gnt, dbg_gnt);
    end
    go_idle(2);
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h10; cpu_wdata = 32'hdeadbeef; #1;
    n_checks++;
    if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_address !== 9'h10 || mem_data_in !== 32'hdeadbeef) begin
      n_fail++;
      $display("FAIL cpu_write: gnt=%b en=%b addr=%h din=%h, required 1/1/010/deadbeef",
               cpu_gnt, mem_en, mem_address, mem_data_in);
    end
    @(negedge clk);
    cpu_we = 1'b0; #1;
    n_checks++;
    if (cpu_gnt !== 1'b1 || mem_en !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_grant: gnt=%b en=%b rvalid=%b, required 1/0/0", cpu_gnt, mem_en, cpu_rvalid);
    end
    @(negedge clk);
    cpu_req = 1'b0; #1;
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hdeadbeef || dbg_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_data: rvalid=%b rdata=%h dbg_rvalid=%b, required 1/deadbeef/0",
               cpu_rvalid, cpu_rdata, dbg_rvalid);
    end
    go_idle(2);
  endtask

  task automatic test_contention();
    int wait_now = 0;
    int wait_max = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h2;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_checks++;
      if (cpu_gnt !== (i % 5 != 4) || dbg_gnt !== (i % 5 == 4)) begin
        n_fail++;
        $display("FAIL contention_pattern: cycle %0d cpu_gnt=%b dbg_gnt=%b, required %b/%b",
                 i, cpu_gnt, dbg_gnt, (i % 5 != 4), (i % 5 == 4));
      end
      if (dbg_gnt === 1'b1) wait_now = 0;
      else wait_now++;
      if (wait_now > wait_max) wait_max = wait_now;
    end
    n_checks++;
    if (wait_max != MAX_HOLD) begin
      n_fail++;
      $display("FAIL contention_max_wait: observed %0d cycles, required %0d", wait_max, MAX_HOLD);
    end
    go_idle(2);
  endtask

  task automatic test_lock();
    @(negedge clk);
    dbg_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h20;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h58; dbg_wdata = 32'h66; #1;
    n_checks++;
    if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1 || mem_en !== 1'b1 || mem_address !== 9'h58) begin
      n_fail++;
      $display("FAIL lock_write0: cpu_gnt=%b dbg_gnt=%b en=%b addr=%h, required 0/1/1/058",
               cpu_gnt, dbg_gnt, mem_en, mem_address);
    end
    @(negedge clk);
    dbg_addr = 9'h6f; dbg_wdata = 32'hcd; #1;
    n_checks++;
    if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1 || mem_en !== 1'b1 || mem_address !== 9'h6f) begin
      n_fail++;
      $display("FAIL lock_write1: cpu_gnt=%b dbg_gnt=%b en=%b addr=%h, required 0/1/1/06f",
               cpu_gnt, dbg_gnt, mem_en, mem_address);
    end
    @(negedge clk);
    dbg_req = 1'b0; #1;
    n_checks++;
    if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_idle_debug: cpu_gnt=%b dbg_gnt=%b, required 0/0", cpu_gnt, dbg_gnt);
    end
    n_checks++;
    if (mem[9'h58] !== 32'h66 || mem[9'h6f] !== 32'hcd) begin
      n_fail++;
      $display("FAIL lock_mem_contents: mem[58]=%h mem[6f]=%h, required 66/cd", mem[9'h58], mem[9'h6f]);
    end
    @(negedge clk);
    dbg_lock = 1'b0; #1;
    n_checks++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_release: cpu_gnt=%b, required 1", cpu_gnt);
    end
    go_idle(2);
  endtask

  task automatic test_alternating();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h1; cpu_wdata = 32'ha;
    @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h2; dbg_wdata = 32'hb;
    @(negedge clk);
    dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; #1;
    n_checks++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_cpu_grant: cpu_gnt=%b dbg_gnt=%b, required 1/0", cpu_gnt, dbg_gnt);
    end
    @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; #1;
    n_checks++;
    if (dbg_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 32'ha || dbg_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_cpu_return: dbg_gnt=%b cpu_rvalid=%b cpu_rdata=%h dbg_rvalid=%b, required 1/1/a/0",
               dbg_gnt, cpu_rvalid, cpu_rdata, dbg_rvalid);
    end
    @(negedge clk);
    dbg_req = 1'b0; #1;
    n_checks++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hb || cpu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_dbg_return: dbg_rvalid=%b dbg_rdata=%h cpu_rvalid=%b, required 1/b/0",
               dbg_rvalid, dbg_rdata, cpu_rvalid);
    end
    go_idle(2);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h2;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrd_grant: cpu_gnt=%b, required 1", cpu_gnt);
    end
    #2 clr = 1'b0;
    @(negedge clk);
    clr = 1'b1; #1;
    n_checks++;
    if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrd_rvalid: cpu_rvalid=%b dbg_rvalid=%b, required 0/0", cpu_rvalid, dbg_rvalid);
    end
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        @(negedge clk); #1;
      end
      n_checks++;
      if (cpu_gnt !== (i != 4) || dbg_gnt !== (i == 4)) begin
        n_fail++;
        $display("FAIL midrd_hold_cleared: cycle %0d cpu_gnt=%b dbg_gnt=%b, required %b/%b",
                 i, cpu_gnt, dbg_gnt, (i != 4), (i == 4));
      end
    end
    go_idle(2);
  endtask

  task automatic test_random();
    bit cpu_pend = 1'b0, dbg_pend = 1'b0;
    bit e_cpu, e_dbg, e_rv_cpu = 1'b0, e_rv_dbg = 1'b0;
    logic [BITS-1:0] e_rdata = '0;
    logic [ADDR_BITS-1:0] e_addr;
    logic [BITS-1:0] e_din;
    logic e_en;
    int streak = 0;
    // known contents for the address window used below
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = ADDR_BITS'(a); dbg_wdata = $urandom;
      ref_mem[a] = dbg_wdata; #1;
      n_checks++;
      if (dbg_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_preload: addr %0d dbg_gnt=%b, required 1", a, dbg_gnt);
      end
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!cpu_pend && $urandom_range(0, 3) != 0) begin
        cpu_pend = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = ADDR_BITS'($urandom_range(0, 15)); cpu_wdata = $urandom;
      end
      if (!dbg_pend && $urandom_range(0, 2) == 0) begin
        dbg_pend = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = ADDR_BITS'($urandom_range(0, 15)); dbg_wdata = $urandom;
      end
      cpu_req = cpu_pend;
      dbg_req = dbg_pend;
      if ($urandom_range(0, 15) == 0) dbg_lock = !dbg_lock;
      // debug wins when locked or when the CPU has used up its streak
      if (dbg_lock || streak == MAX_HOLD) begin
        e_dbg = dbg_req;
        e_cpu = cpu_req && !dbg_req && !dbg_lock;
      end else begin
        e_cpu = cpu_req;
        e_dbg = dbg_req && !cpu_req;
      end
      e_addr = e_cpu ? cpu_addr : (e_dbg ? dbg_addr : '0);
      e_din  = e_cpu ? cpu_wdata : (e_dbg ? dbg_wdata : '0);
      e_en   = (e_cpu && cpu_we) || (e_dbg && dbg_we);
      #1;
      n_checks++;
      if (cpu_gnt !== e_cpu || dbg_gnt !== e_dbg) begin
        n_fail++;
        $display("FAIL rand_grant: cycle %0d cpu_gnt=%b dbg_gnt=%b, required %b/%b", cyc, cpu_gnt, dbg_gnt, e_cpu, e_dbg);
      end
      n_checks++;
      if (mem_en !== e_en || mem_address !== e_addr || mem_data_in !== e_din) begin
        n_fail++;
        $display("FAIL rand_mem_bus: cycle %0d en=%b addr=%h din=%h, required %b/%h/%h",
                 cyc, mem_en, mem_address, mem_data_in, e_en, e_addr, e_din);
      end
      n_checks++;
      if (cpu_rvalid !== e_rv_cpu || dbg_rvalid !== e_rv_dbg ||
          (e_rv_cpu && cpu_rdata !== e_rdata) || (e_rv_dbg && dbg_rdata !== e_rdata)) begin
        n_fail++;
        $display("FAIL rand_read_return: cycle %0d rvalid=%b/%b rdata=%h/%h, required %b/%b data %h",
                 cyc, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, e_rv_cpu, e_rv_dbg, e_rdata);
      end
      @(posedge clk);
      e_rv_cpu = e_cpu && !cpu_we;
      e_rv_dbg = e_dbg && !dbg_we;
      if (e_rv_cpu) e_rdata = ref_mem[cpu_addr[3:0]];
      if (e_rv_dbg) e_rdata = ref_mem[dbg_addr[3:0]];
      if (e_cpu && cpu_we) ref_mem[cpu_addr[3:0]] = cpu_wdata;
      if (e_dbg && dbg_we) ref_mem[dbg_addr[3:0]] = dbg_wdata;
      if (streak == MAX_HOLD || e_dbg || !dbg_req) streak = 0;
      else if (e_cpu) streak++;
      if (e_cpu) cpu_pend = 1'b0;
      if (e_dbg) dbg_pend = 1'b0;
    end
    go_idle(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_contention();
    test_lock();
    test_alternating();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the CPU's single-port 512-word memory between the CPU datapath (fetch / load / store) and an external debug/loader port used to download programs and inspect memory. Sits between the requesters and the memory block, driving its address, data_in and write enable. The CPU has fixed priority, but a bounded-starvation rule and an exclusive debug lock guarantee debug progress. Read data follows the memory's one-cycle registered-output latency.

## Interface
Parameters:
- BITS, 32, data word width
- WORDS, 512, memory depth in words
- ADDR_BITS, $clog2(WORDS), address width
- MAX_HOLD, 8, max consecutive CPU grants while debug waits (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  reset; synchronous and active-low
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_BITS  CPU word address
- cpu_wdata  in  BITS  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid this cycle
- cpu_rdata  out  BITS  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_BITS/BITS  debug request fields, same meaning as CPU
- dbg_lock  in  1  exclusive debug ownership; CPU never granted while high
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/BITS  debug grant / read valid / read data
- mem_address  out  ADDR_BITS  to memory address
- mem_data_in  out  BITS  to memory write data
- mem_en  out  1  memory write enable
- mem_data_out  in  BITS  memory registered read data

## Operation
- Requester holds req/we/addr/wdata stable until it sees gnt high; gnt is a single-cycle acknowledge. A requester that keeps req high after gnt is issuing a new access.
- At most one gnt per cycle. mem_address/mem_data_in are taken from the granted port. mem_en = granted & we.
- No grant: mem_address = 0, mem_data_in = 0, mem_en = 0.
- cpu_rdata = dbg_rdata = mem_data_out (pass-through); only qualified by rvalid.
- FSM states: S_CPU (CPU priority), S_DBG (debug priority for one slot).
- S_CPU: dbg_lock → grant dbg if dbg_req. Else cpu_req → grant CPU. Else dbg_req → grant dbg.
- S_DBG: dbg_req → grant dbg. Else cpu_req and !dbg_lock → grant CPU. Always returns to S_CPU.
- hold_cnt (0..MAX_HOLD): +1 on each CPU grant while dbg_req = 1; cleared on any dbg grant, on any cycle with dbg_req = 0, and on entering S_DBG.
- S_CPU → S_DBG when hold_cnt reaches MAX_HOLD. The following cycle is the forced debug slot.
- Read tracking: rd_owner register and rd_pending flag capture {granted port, !we} each cycle.
- rvalid is asserted for the owner in the cycle after a granted read. Back-to-back reads by alternating owners are routed correctly each cycle.
- dbg_lock asserted mid-stream: it takes effect the same cycle. A CPU read granted in the previous cycle still gets its cpu_rvalid.

## Timing
- Grant: combinational, in the same cycle as req (0-cycle arbitration latency).
- Write: committed at the clock edge ending the grant cycle.
- Read latency: exactly 1 cycle from grant to rvalid.
- Throughput: one access per cycle.
- Worst-case debug wait with cpu_req continuously high: MAX_HOLD cycles.
- Reset (clr = 0 at an edge): state = S_CPU, hold_cnt = 0, rd_pending = 0.
- During reset: all gnt/rvalid/mem_en = 0, mem_address = 0, mem_data_in = 0, regardless of req.
- Reset mid-read: the pending rvalid is discarded and not asserted after clr releases.
- First grant is possible in the first cycle with clr = 1.

## Structure
- Shared package/header holds: state encodings S_CPU/S_DBG, owner encodings OWNER_CPU = 0 / OWNER_DBG = 1, default WORDS = 512.
- One sub-module is natural: arbiter_hold_counter, a saturating counter with inc, clear and at_max outputs, parameterised by MAX_HOLD.
- FSM, grant mux and read-tracking registers live in memory_arbiter; RTL is about 150–250 lines.

## Test plan
- Reset: hold clr = 0 with both reqs high → all outputs 0. Release → cpu_gnt in the first cycle.
- CPU read: memory[0x10] = 0xdeadbeef, cpu_req read 0x10 → cpu_gnt in cycle N, cpu_rvalid = 1 with cpu_rdata = 0xdeadbeef in N+1. dbg_rvalid stays 0.
- Contention, MAX_HOLD = 4: both reqs held high → grant pattern CPU,CPU,CPU,CPU,DBG repeating. No dbg wait exceeds 4 cycles.
- Lock: dbg_lock = 1, cpu_req high, dbg writes 0x66 to 0x58 then 0xcd to 0x6f → cpu_gnt is 0 throughout, and memory holds both words afterwards.
- Alternating reads: CPU reads 0x01 (=0xa), debug reads 0x02 (=0xb) on consecutive cycles → cpu_rvalid/0xa then dbg_rvalid/0xb on consecutive cycles, never both high.
- Reset mid-read: CPU read granted in cycle N, clr = 0 at the edge ending N → no cpu_rvalid in N+1 or later, and hold_cnt = 0.
